// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM state
// encoding and the default datapath width.
package alu_pkg;

   localparam int WIDTH = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MULT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_MUL  = 2'b10,
      S_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bundle of the request handshake and the external ALU operand/select/result
// buses seen by the sequencer.
interface alu_op_sequencer_if #(
   parameter int WIDTH = alu_pkg::WIDTH
);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_select;
   logic [WIDTH-1:0] alu_result;

   // The master side owns both the requester and the external ALU/mux bank.
   modport master (
      output start, op, a, b, alu_result,
      input  ready, done, result, zero, alu_a, alu_b, alu_select
   );

   modport slave (
      input  start, op, a, b, alu_result,
      output ready, done, result, zero, alu_a, alu_b, alu_select
   );

endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller for an external ALU: routes operands and the result
// select, captures the result, and runs MULT as a shift-add loop on the ADD path.
module alu_op_sequencer #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   alu_op_sequencer_if.slave bus
);

   import alu_pkg::*;

   localparam int              CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e           r_state;
   state_e           w_nextState;

   // The ALU operand/select registers double as the latched request: in EXEC
   // they hold a/b/op, in MUL alu_a is the accumulator and alu_b the multiplicand.
   logic [WIDTH-1:0] r_aluA;
   logic [WIDTH-1:0] r_aluB;
   logic [2:0]       r_aluSel;
   logic [WIDTH-1:0] r_mplier;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;

   logic             w_accept;
   logic             w_lastStep;
   logic             w_ready;
   logic             w_done;
   logic [WIDTH-1:0] w_accNext;
   logic [WIDTH-1:0] w_aluANext;
   logic [WIDTH-1:0] w_aluBNext;
   logic [2:0]       w_aluSelNext;

   assign w_accept   = bus.start && (r_state == S_IDLE);
   assign w_lastStep = (r_cnt == LAST_STEP);
   assign w_accNext  = r_mplier[0] ? bus.alu_result : r_aluA;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_nextState = (bus.op == OP_MULT) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC: w_nextState = S_DONE;
         S_MUL: begin
            if (w_lastStep) begin
               w_nextState = S_DONE;
            end
         end
         S_DONE: w_nextState = S_IDLE;
      endcase
   end

   // Next values for the registered ALU drive, so alu_a/alu_b/alu_select come
   // straight from flops and the external mux bank gets a full cycle to settle.
   always_comb begin
      w_aluANext   = '0;
      w_aluBNext   = '0;
      w_aluSelNext = OP_AND;
      w_ready      = 1'b0;
      w_done       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (w_accept) begin
               if (bus.op == OP_MULT) begin
                  w_aluSelNext = OP_ADD;
                  w_aluBNext   = bus.a;
               end else begin
                  w_aluSelNext = bus.op;
                  w_aluANext   = bus.a;
                  w_aluBNext   = bus.b;
               end
            end
         end
         S_EXEC: begin
         end
         S_MUL: begin
            if (!w_lastStep) begin
               w_aluSelNext = OP_ADD;
               w_aluANext   = w_accNext;
               w_aluBNext   = r_aluB << 1;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aluA   <= '0;
         r_aluB   <= '0;
         r_aluSel <= OP_AND;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
      end else begin
         r_aluA   <= w_aluANext;
         r_aluB   <= w_aluBNext;
         r_aluSel <= w_aluSelNext;

         if (w_accept) begin
            r_mplier <= bus.b;
            r_cnt    <= '0;
         end else if (r_state == S_MUL) begin
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
         end

         // The final MUL step still accumulates, so capture its outcome directly.
         if (r_state == S_EXEC) begin
            r_result <= bus.alu_result;
            r_zero   <= (bus.alu_result == '0);
         end else if ((r_state == S_MUL) && w_lastStep) begin
            r_result <= w_accNext;
            r_zero   <= (w_accNext == '0);
         end
      end
   end

   assign bus.alu_a      = r_aluA;
   assign bus.alu_b      = r_aluB;
   assign bus.alu_select = r_aluSel;
   assign bus.ready      = w_ready;
   assign bus.done       = w_done;
   assign bus.result     = r_result;
   assign bus.zero       = r_zero;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: models the external ALU, predicts each
// accepted request's result and done cycle, and checks them as done pulses arrive.
module tb_alu_op_sequencer;

   import alu_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          doneCycle;
   } exp_t;

   logic clk;
   logic reset;

   alu_op_sequencer_if #(.WIDTH(WIDTH)) bus();

   alu_op_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   exp_t expQ[$];
   exp_t pushed;
   exp_t popped;
   int   total = 0;
   int   bad   = 0;
   int   cycle = 0;

   // Behaviour of the external ALU plus result-select mux bank.
   function automatic logic [31:0] aluFn(input logic [2:0] sel, input logic [31:0] x,
                                         input logic [31:0] y);
      case (sel)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x | y);
         3'd4:    return x + y;
         3'd5:    return x - y;
         3'd6:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
      logic [31:0] prod;
      prod = x * y;
      return (op == 3'd7) ? prod : aluFn(op, x, y);
   endfunction

   always_comb bus.alu_result = aluFn(bus.alu_select, bus.alu_a, bus.alu_b);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x,
                                input logic [31:0] y);
      int n;
      n = 0;
      while (bus.ready !== 1'b1 && n < 200) begin
         stepCycle();
         n++;
      end
      if (n >= 200) begin
         total++;
         bad++;
         $display("[TB] FAIL ready_timeout: got ready=%b, expected 1 within 200 cycles", bus.ready);
      end
      bus.op    = op;
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || bus.ready !== 1'b1) && n < 300) begin
         stepCycle();
         n++;
      end
      if (n >= 300) begin
         total++;
         bad++;
         $display("[TB] FAIL idle_timeout: got pending=%0d ready=%b, expected 0 and 1",
                  expQ.size(), bus.ready);
      end
   endtask

   // Request side of the scoreboard: every accepted request predicts its outcome.
   always @(posedge clk) begin
      cycle = cycle + 1;
      if (!reset && bus.start === 1'b1 && bus.ready === 1'b1) begin
         pushed.res       = refModel(bus.op, bus.a, bus.b);
         pushed.doneCycle = cycle + ((bus.op == 3'd7) ? WIDTH : 1);
         expQ.push_back(pushed);
      end
   end

   // Response side: each done pulse must match the oldest outstanding prediction.
   always @(negedge clk) begin
      if (!reset && bus.done === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: got done=1 with result 0x%08h, expected no pending op",
                     bus.result);
         end else begin
            popped = expQ.pop_front();
            checkOutput("result", bus.result, popped.res);
            checkOutput("zero", {31'b0, bus.zero}, {31'b0, (popped.res == 32'd0)});
            checkOutput("done_cycle", cycle, popped.doneCycle);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int selCnt;
      int rdyCnt;
      int doneCnt;
      logic [2:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      #2;
      checkOutput("reset_ready", {31'b0, bus.ready}, 32'd1);
      checkOutput("reset_done", {31'b0, bus.done}, 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      checkOutput("reset_zero", {31'b0, bus.zero}, 32'd1);
      checkOutput("reset_select", {29'b0, bus.alu_select}, 32'd0);
      stepCycle();
      reset = 1'b0;
      stepCycle();

      $display("[TB] ADD 5+3");
      applyStimulus(OP_ADD, 32'h0000_0005, 32'h0000_0003);
      checkOutput("exec_select", {29'b0, bus.alu_select}, 32'd4);
      checkOutput("exec_alu_a", bus.alu_a, 32'd5);
      checkOutput("exec_alu_b", bus.alu_b, 32'd3);
      waitIdle();

      $display("[TB] SUB to zero");
      applyStimulus(OP_SUB, 32'h1234_5678, 32'h1234_5678);
      waitIdle();

      $display("[TB] MULT 7*6");
      applyStimulus(OP_MULT, 32'd7, 32'd6);
      selCnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.alu_select == 3'd4) selCnt++;
         stepCycle();
      end
      checkOutput("mul_select_cycles", selCnt, 32'd32);
      waitIdle();

      $display("[TB] MULT 0xFFFFFFFF*2");
      applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2);
      waitIdle();

      $display("[TB] busy rejection");
      applyStimulus(OP_MULT, 32'h0001_2345, 32'h0000_0ABC);
      repeat (4) stepCycle();
      checkOutput("busy_ready_mul", {31'b0, bus.ready}, 32'd0);
      bus.op    = OP_AND;
      bus.a     = 32'hFFFF_FFFF;
      bus.b     = 32'hFFFF_FFFF;
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      selCnt = 0;
      while (bus.done !== 1'b1 && selCnt < 60) begin
         stepCycle();
         selCnt++;
      end
      checkOutput("busy_done_seen", {31'b0, bus.done}, 32'd1);
      checkOutput("busy_ready_done", {31'b0, bus.ready}, 32'd0);
      bus.start = 1'b1;
      stepCycle();
      bus.start = 1'b0;
      waitIdle();
      repeat (5) stepCycle();

      $display("[TB] back-to-back OR");
      bus.op    = OP_OR;
      bus.a     = 32'h0000_00F0;
      bus.b     = 32'h0000_000F;
      bus.start = 1'b1;
      rdyCnt    = 0;
      doneCnt   = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.ready === 1'b1) rdyCnt++;
         if (bus.done === 1'b1) doneCnt++;
         stepCycle();
      end
      bus.start = 1'b0;
      checkOutput("b2b_ready_cycles", rdyCnt, 32'd4);
      checkOutput("b2b_done_pulses", doneCnt, 32'd4);
      waitIdle();

      $display("[TB] random operations");
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 5 == 0) rb = ra;
         if (i % 7 == 0) rb = 32'($urandom_range(0, 15));
         applyStimulus(rop, ra, rb);
         if (i % 3 == 0) waitIdle();
      end
      waitIdle();

      $display("[TB] reset during MULT");
      applyStimulus(OP_ADD, 32'd1, 32'd1);
      waitIdle();
      applyStimulus(OP_MULT, 32'd3, 32'd5);
      repeat (8) stepCycle();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("midreset_ready", {31'b0, bus.ready}, 32'd1);
      checkOutput("midreset_done", {31'b0, bus.done}, 32'd0);
      checkOutput("midreset_result", bus.result, 32'd0);
      checkOutput("midreset_zero", {31'b0, bus.zero}, 32'd1);
      checkOutput("midreset_select", {29'b0, bus.alu_select}, 32'd0);
      checkOutput("midreset_alu_a", bus.alu_a, 32'd0);
      checkOutput("midreset_alu_b", bus.alu_b, 32'd0);
      expQ.delete();
      stepCycle();
      reset = 1'b0;
      stepCycle();
      applyStimulus(OP_ADD, 32'h0000_0010, 32'h0000_0020);
      waitIdle();
      repeat (3) stepCycle();

      checkOutput("pending_at_end", expQ.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
